// File: rtl/cnt_seq_ctrl.sv
// rtl/cnt_seq_ctrl.sv - run/pause/done sequencer and tick prescaler for the 4-bit display counter.
// Optional CSC_STEP_EN adds csc_step: single tick decisions while paused.
module cnt_seq_ctrl #(
  parameter int CNT_W    = 4,
  parameter int MAX_VAL  = 15,
  parameter int PRESCALE = 4
) (
  input  logic             csc_clk,
  input  logic             csc_rst_n,
  input  logic             csc_start,
  input  logic             csc_stop,
  input  logic             csc_dir,
  input  logic             csc_wrap,
`ifdef CSC_STEP_EN
  input  logic             csc_step,
`endif
  input  logic [CNT_W-1:0] csc_cnt_q,
  output logic             csc_cnt_en,
  output logic             csc_cnt_up,
  output logic             csc_cnt_clr,
  output logic [1:0]       csc_state
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] MAX_Q      = CNT_W'(MAX_VAL);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          start_d1_q, start_d1_d;
  logic          stop_d1_q, stop_d1_d;
  logic          cnt_en_q, cnt_en_d;
  logic          cnt_clr_q, cnt_clr_d;
  logic          cnt_up_q, cnt_up_d;
  logic          start_rise, stop_rise, step_rise;
  logic          decide, at_limit;

`ifdef CSC_STEP_EN
  logic          step_d1_q, step_d1_d;
  assign step_rise = csc_step & ~step_d1_q;
`else
  assign step_rise = 1'b0;
`endif

  assign start_rise = csc_start & ~start_d1_q;
  assign stop_rise  = csc_stop & ~stop_d1_q;

  // Limit test uses the direction the datapath is currently applying.
  assign at_limit = cnt_up_q ? (csc_cnt_q >= MAX_Q) : (csc_cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    cnt_en_d   = 1'b0;
    cnt_clr_d  = 1'b0;
    cnt_up_d   = csc_dir;
    start_d1_d = csc_start;
    stop_d1_d  = csc_stop;
`ifdef CSC_STEP_EN
    step_d1_d  = csc_step;
`endif
    decide     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!stop_rise && start_rise) begin
          state_d = ST_RUN;
          presc_d = '0;
        end
      end
      ST_RUN: begin
        if (stop_rise) begin
          state_d = ST_PAUSE;
        end else if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          decide  = 1'b1;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      ST_PAUSE: begin
        if (stop_rise) begin
          state_d   = ST_IDLE;
          presc_d   = '0;
          cnt_clr_d = 1'b1;
        end else if (start_rise) begin
          state_d = ST_RUN;
        end else if (step_rise) begin
          decide = 1'b1;
        end
      end
      ST_DONE: begin
        if (stop_rise) begin
          state_d   = ST_IDLE;
          presc_d   = '0;
          cnt_clr_d = 1'b1;
        end else if (start_rise) begin
          state_d   = ST_RUN;
          presc_d   = '0;
          cnt_clr_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Down-wrap relies on the datapath rolling over modulo 2^CNT_W.
    if (decide) begin
      if (!at_limit) begin
        cnt_en_d = 1'b1;
      end else if (!csc_wrap) begin
        state_d = ST_DONE;
      end else if (cnt_up_q) begin
        cnt_clr_d = 1'b1;
      end else begin
        cnt_en_d = 1'b1;
      end
    end
  end

  always_ff @(posedge csc_clk or negedge csc_rst_n) begin
    if (!csc_rst_n) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      start_d1_q <= 1'b0;
      stop_d1_q  <= 1'b0;
      cnt_en_q   <= 1'b0;
      cnt_clr_q  <= 1'b0;
      cnt_up_q   <= 1'b1;
`ifdef CSC_STEP_EN
      step_d1_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      start_d1_q <= start_d1_d;
      stop_d1_q  <= stop_d1_d;
      cnt_en_q   <= cnt_en_d;
      cnt_clr_q  <= cnt_clr_d;
      cnt_up_q   <= cnt_up_d;
`ifdef CSC_STEP_EN
      step_d1_q  <= step_d1_d;
`endif
    end
  end

  assign csc_cnt_en  = cnt_en_q;
  assign csc_cnt_clr = cnt_clr_q;
  assign csc_cnt_up  = cnt_up_q;
  assign csc_state   = state_q;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// tb/tb_cnt_seq_ctrl.sv - directed and randomized bench for cnt_seq_ctrl with a counter plant and reference model.
// Honours CSC_STEP_EN when defined.
module tb_cnt_seq_ctrl;
  localparam int CNT_W = 4, MAX_VAL = 9, PRESCALE = 4;
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_DONE = 2'd3;
`ifdef CSC_STEP_EN
  localparam bit HAS_STEP = 1'b1;
`else
  localparam bit HAS_STEP = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, stop = 1'b0, dir = 1'b1, wrap = 1'b1, step = 1'b0;
  logic [CNT_W-1:0] q;
  logic en, up, clr;
  logic [1:0] state;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  cnt_seq_ctrl #(.CNT_W(CNT_W), .MAX_VAL(MAX_VAL), .PRESCALE(PRESCALE)) dut (
    .csc_clk(clk), .csc_rst_n(rst_n), .csc_start(start), .csc_stop(stop),
    .csc_dir(dir), .csc_wrap(wrap),
`ifdef CSC_STEP_EN
    .csc_step(step),
`endif
    .csc_cnt_q(q), .csc_cnt_en(en), .csc_cnt_up(up), .csc_cnt_clr(clr), .csc_state(state)
  );

  // Counter datapath plant driven by the DUT pulses.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (clr) q <= '0;
    else if (en) q <= up ? q + 1'b1 : q - 1'b1;

  // Reference model: button rules, tick phase and its own counter value.
  logic [1:0] m_st;
  int m_phase;
  logic m_en, m_clr, m_up, o_en, o_clr, decide, lim;
  logic [CNT_W-1:0] m_q;
  logic p_start, p_stop, p_step, r_start, r_stop, r_step;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = S_IDLE; m_phase = 0; m_en = 0; m_clr = 0; m_up = 1; m_q = '0;
      p_start = 0; p_stop = 0; p_step = 0;
    end else begin
      r_start = start & ~p_start;
      r_stop  = stop & ~p_stop;
      r_step  = step & ~p_step & HAS_STEP;
      o_en = m_en; o_clr = m_clr;
      m_en = 0; m_clr = 0; decide = 0;
      if (r_stop) begin
        if (m_st == S_RUN) m_st = S_PAUSE;
        else if (m_st != S_IDLE) begin m_st = S_IDLE; m_clr = 1; end
      end else if (r_start && m_st != S_RUN) begin
        if (m_st != S_PAUSE) m_phase = 0;
        m_clr = (m_st == S_DONE);
        m_st = S_RUN;
      end else if (m_st == S_RUN) begin
        m_phase = (m_phase + 1) % PRESCALE;
        decide = (m_phase == 0);
      end else if (m_st == S_PAUSE && r_step) begin
        decide = 1;
      end
      if (decide) begin
        lim = m_up ? (int'(m_q) >= MAX_VAL) : (m_q == 0);
        if (!lim) m_en = 1;
        else if (!wrap) m_st = S_DONE;
        else if (m_up) m_clr = 1;
        else m_en = 1;
      end
      if (o_clr) m_q = '0;
      else if (o_en) m_q = m_up ? m_q + 1'b1 : m_q - 1'b1;
      m_up = dir;
      p_start = start; p_stop = stop; p_step = step;
    end
  end

  task automatic do_reset;
    rst_n = 0; start = 0; stop = 0; step = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1;
  endtask

  task automatic wait_pulse(output int cyc, output logic ok);
    cyc = 0; ok = 0;
    while (cyc < 12 && !ok) begin
      @(negedge clk); cyc++; ok = en | clr;
    end
  endtask

  task automatic test_reset;
    int c; logic ok; int bad;
    do_reset; dir = 1; wrap = 1;
    @(negedge clk);
    checks++;
    if ({en, clr, up, state} !== 5'b00100) begin
      errors++; $display("FAIL reset_state got %b exp 00100", {en, clr, up, state});
    end
    start = 1;
    wait_pulse(c, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_run_pulse got none exp pulse within 12"); end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({en, clr, up, state} !== 5'b00100) begin
      errors++; $display("FAIL reset_async got %b exp 00100", {en, clr, up, state});
    end
    @(negedge clk); rst_n = 1; start = 0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (state !== S_IDLE || en !== 1'b0 || clr !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL idle_after_reset got %0d bad cycles exp 0", bad); end
  endtask

  task automatic test_wrap_up;
    int c; logic ok; int exp_q;
    do_reset; dir = 1; wrap = 1;
    start = 1; @(negedge clk); start = 0;
    exp_q = 0;
    for (int k = 0; k < 13; k++) begin
      wait_pulse(c, ok);
      checks++;
      if (!ok || c != (k == 0 ? 4 : 3)) begin
        errors++; $display("FAIL tick_interval k=%0d got ok=%0b cyc=%0d exp cyc=%0d", k, ok, c, (k == 0 ? 4 : 3));
      end
      checks++;
      if ({en, clr} !== (exp_q == MAX_VAL ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL pulse_kind q=%0d got en/clr=%b exp %b", exp_q, {en, clr}, (exp_q == MAX_VAL ? 2'b01 : 2'b10));
      end
      exp_q = (exp_q == MAX_VAL) ? 0 : exp_q + 1;
      @(negedge clk);
      checks++;
      if (q !== CNT_W'(exp_q)) begin errors++; $display("FAIL wrap_up_q got %0d exp %0d", q, exp_q); end
    end
  endtask

  task automatic test_halt_up;
    int c; int p;
    do_reset; dir = 1; wrap = 0;
    start = 1; @(negedge clk); start = 0;
    c = 0;
    while (state !== S_DONE && c < 80) begin @(negedge clk); c++; end
    checks++;
    if (state !== S_DONE || q !== 4'd9) begin
      errors++; $display("FAIL halt_reached got state=%0d q=%0d exp state=3 q=9", state, q);
    end
    p = 0;
    repeat (12) begin @(negedge clk); if (en | clr) p++; end
    checks++;
    if (p != 0 || state !== S_DONE) begin
      errors++; $display("FAIL done_quiet got pulses=%0d state=%0d exp 0 and 3", p, state);
    end
    stop = 1; @(negedge clk);
    checks++;
    if ({clr, en, state} !== 4'b1000) begin
      errors++; $display("FAIL stop_clr got clr/en/state=%b exp 1000", {clr, en, state});
    end
    stop = 0; @(negedge clk);
    checks++;
    if (q !== 4'd0 || clr !== 1'b0) begin errors++; $display("FAIL cleared got q=%0d clr=%0b exp 0 0", q, clr); end
  endtask

  task automatic test_pause_phase;
    int p;
    do_reset; dir = 1; wrap = 1;
    start = 1; @(negedge clk); start = 0;
    @(negedge clk); @(negedge clk);
    stop = 1; @(negedge clk);
    checks++;
    if (state !== S_PAUSE) begin errors++; $display("FAIL pause_on_stop got %0d exp 2", state); end
    stop = 0; p = 0;
    repeat (5) begin @(negedge clk); if (en | clr) p++; end
    checks++;
    if (p != 0 || state !== S_PAUSE) begin
      errors++; $display("FAIL pause_quiet got pulses=%0d state=%0d exp 0 and 2", p, state);
    end
    start = 1; @(negedge clk);
    checks++;
    if (state !== S_RUN || en !== 1'b0) begin
      errors++; $display("FAIL resume got state=%0d en=%0b exp 1 0", state, en);
    end
    start = 0; @(negedge clk);
    checks++;
    if (en !== 1'b0) begin errors++; $display("FAIL resume_no_early got en=%0b exp 0", en); end
    @(negedge clk);
    checks++;
    if (en !== 1'b1) begin errors++; $display("FAIL resume_phase got en=%0b exp 1", en); end
  endtask

  task automatic test_down;
    int c; logic ok; int p;
    do_reset; dir = 0; wrap = 1;
    start = 1; @(negedge clk); start = 0;
    wait_pulse(c, ok);
    checks++;
    if (!ok || en !== 1'b1 || clr !== 1'b0) begin
      errors++; $display("FAIL down_wrap_en got ok=%0b en=%0b clr=%0b exp 1 1 0", ok, en, clr);
    end
    @(negedge clk);
    checks++;
    if (q !== 4'd15) begin errors++; $display("FAIL down_wrap_q got %0d exp 15", q); end
    do_reset; dir = 0; wrap = 0;
    start = 1; @(negedge clk); start = 0;
    c = 0; p = 0;
    while (state !== S_DONE && c < 20) begin @(negedge clk); c++; if (en | clr) p++; end
    checks++;
    if (state !== S_DONE || p != 0 || q !== 4'd0) begin
      errors++; $display("FAIL down_halt got state=%0d pulses=%0d q=%0d exp 3 0 0", state, p, q);
    end
  endtask

  task automatic test_same_cycle;
    do_reset; dir = 1; wrap = 1;
    start = 1; @(negedge clk); start = 0;
    @(negedge clk); @(negedge clk);
    start = 1; stop = 1; @(negedge clk);
    checks++;
    if (state !== S_PAUSE) begin errors++; $display("FAIL start_stop_same got %0d exp 2", state); end
    start = 0; stop = 0;
  endtask

`ifdef CSC_STEP_EN
  task automatic test_step;
    int c; int p;
    do_reset; dir = 1; wrap = 0;
    start = 1; @(negedge clk); start = 0;
    c = 0;
    while (q !== 4'd8 && c < 60) begin @(negedge clk); c++; end
    stop = 1; @(negedge clk); stop = 0;
    checks++;
    if (state !== S_PAUSE || q !== 4'd8) begin
      errors++; $display("FAIL step_pause got state=%0d q=%0d exp 2 8", state, q);
    end
    p = 0;
    repeat (3) begin
      step = 1; @(negedge clk); if (en | clr) p++;
      step = 0; @(negedge clk); if (en | clr) p++;
    end
    @(negedge clk);
    checks++;
    if (q !== 4'd9 || state !== S_DONE || p != 1) begin
      errors++; $display("FAIL step_done got q=%0d state=%0d pulses=%0d exp 9 3 1", q, state, p);
    end
  endtask
`endif

  task automatic test_random;
    do_reset;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      checks++;
      if ({en, clr, up, state, q} !== {m_en, m_clr, m_up, m_st, m_q}) begin
        errors++;
        $display("FAIL lockstep cyc=%0d got en/clr/up/st/q=%b exp %b", i, {en, clr, up, state, q}, {m_en, m_clr, m_up, m_st, m_q});
      end
      if ($urandom_range(0, 5) == 0) start = ~start;
      if ($urandom_range(0, 13) == 0) stop = ~stop;
      if ($urandom_range(0, 3) == 0) step = ~step;
      if ($urandom_range(0, 39) == 0) dir = ~dir;
      if ($urandom_range(0, 59) == 0) wrap = ~wrap;
      rst_n = ($urandom_range(0, 699) != 0);
    end
    rst_n = 1;
  endtask

  initial begin
    test_reset;
    test_wrap_up;
    test_halt_up;
    test_pause_phase;
    test_down;
    test_same_cycle;
`ifdef CSC_STEP_EN
    test_step;
`endif
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
